// File: rtl/mano_timing_ctrl.sv
// MANO CPU timing and sequence controller: SC step control, T-line decode,
// opcode/I latch and the R, S and IEN flip-flops.
module mano_timing_ctrl #(
    parameter int SEQW = 4,
    parameter int NT   = 2 ** SEQW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SEQW-1:0] t,
    input  logic [15:0]     ir,
    input  logic            fgi,
    input  logic            fgo,
    input  logic            start,
    output logic            sc_inc,
    output logic            sc_clr,
    output logic [NT-1:0]   tsig,
    output logic [7:0]      d,
    output logic            i_bit,
    output logic            r,
    output logic            s,
    output logic            ien,
    output logic [2:0]      phase,
    output logic            instr_done,
    output logic            err
);

    localparam logic [2:0] PH_HALT   = 3'd0;
    localparam logic [2:0] PH_FETCH  = 3'd1;
    localparam logic [2:0] PH_DECODE = 3'd2;
    localparam logic [2:0] PH_IND    = 3'd3;
    localparam logic [2:0] PH_EXEC   = 3'd4;
    localparam logic [2:0] PH_INTR   = 3'd5;

    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            ien_q, ien_d;
    logic            i_q, i_d;
    logic            err_q, err_d;
    logic [7:0]      d_q, d_d;
    logic [SEQW-1:0] end_t;
    logic            illegal;
    logic            unused_ir;

    assign unused_ir = ^{ir[11:8], ir[5:1]};

    assign tsig = NT'(1) << t;

    assign illegal = s_q && (t > (r_q ? SEQW'(2) : SEQW'(6)));

    // Last execute step of a memory-reference instruction.
    always_comb begin
        end_t = SEQW'(6);
        if (d_q[3] | d_q[4]) begin
            end_t = SEQW'(4);
        end else if (d_q[0] | d_q[1] | d_q[2] | d_q[5]) begin
            end_t = SEQW'(5);
        end
    end

    always_comb begin
        sc_inc     = 1'b0;
        sc_clr     = 1'b0;
        instr_done = 1'b0;
        phase      = PH_HALT;
        if (rst) begin
            sc_clr = 1'b1;
        end else if (!s_q) begin
            phase = PH_HALT;
        end else if (illegal) begin
            sc_clr = 1'b1;
            phase  = r_q ? PH_INTR : PH_EXEC;
        end else if (r_q) begin
            phase = PH_INTR;
            if (t == SEQW'(2)) sc_clr = 1'b1;
            else               sc_inc = 1'b1;
        end else if (t <= SEQW'(1)) begin
            phase  = PH_FETCH;
            sc_inc = 1'b1;
        end else if (t == SEQW'(2)) begin
            phase  = PH_DECODE;
            sc_inc = 1'b1;
        end else if (t == SEQW'(3)) begin
            if (d_q[7]) begin
                phase      = PH_EXEC;
                sc_clr     = 1'b1;
                instr_done = 1'b1;
            end else begin
                phase  = i_q ? PH_IND : PH_EXEC;
                sc_inc = 1'b1;
            end
        end else begin
            phase = PH_EXEC;
            if (t >= end_t) begin
                sc_clr     = 1'b1;
                instr_done = (t == end_t);
            end else begin
                sc_inc = 1'b1;
            end
        end
    end

    always_comb begin
        s_d   = s_q;
        r_d   = r_q;
        ien_d = ien_q;
        i_d   = i_q;
        err_d = err_q;
        d_d   = d_q;
        if (!s_q) begin
            if (start) s_d = 1'b1;
        end else begin
            if (!r_q) begin
                if (t == SEQW'(2)) begin
                    d_d = 8'(1) << ir[14:12];
                    i_d = ir[15];
                end
                if (t == SEQW'(3) && d_q[7]) begin
                    if (!i_q) begin
                        if (ir[0]) s_d = 1'b0;
                    end else if (ir[6]) begin
                        ien_d = 1'b0;
                    end else if (ir[7]) begin
                        ien_d = 1'b1;
                    end
                end
                // Entry sees the pre-edge IEN, so IOF cannot block it.
                if (t > SEQW'(2) && ien_q && (fgi | fgo)) r_d = 1'b1;
            end else if (t == SEQW'(2)) begin
                r_d   = 1'b0;
                ien_d = 1'b0;
            end
            if (illegal) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= 1'b0;
            r_q   <= 1'b0;
            ien_q <= 1'b0;
            i_q   <= 1'b0;
            err_q <= 1'b0;
            d_q   <= 8'd0;
        end else begin
            s_q   <= s_d;
            r_q   <= r_d;
            ien_q <= ien_d;
            i_q   <= i_d;
            err_q <= err_d;
            d_q   <= d_d;
        end
    end

    assign s     = s_q;
    assign r     = r_q;
    assign ien   = ien_q;
    assign i_bit = i_q;
    assign err   = err_q;
    assign d     = d_q;

endmodule

// File: tb/tb_mano_timing_ctrl.sv
// Directed bench for mano_timing_ctrl; models the external SC from
// sc_inc/sc_clr and checks hand-computed expectations.
module tb_mano_timing_ctrl;

    localparam int SEQW = 4;
    localparam int NT   = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [SEQW-1:0] t;
    logic [15:0]     ir;
    logic            fgi, fgo, start;
    logic            sc_inc, sc_clr, i_bit, r, s, ien, instr_done, err;
    logic [NT-1:0]   tsig;
    logic [7:0]      d;
    logic [2:0]      phase;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mano_timing_ctrl #(.SEQW(SEQW), .NT(NT)) dut (
        .clk        (clk),
        .rst        (rst),
        .t          (t),
        .ir         (ir),
        .fgi        (fgi),
        .fgo        (fgo),
        .start      (start),
        .sc_inc     (sc_inc),
        .sc_clr     (sc_clr),
        .tsig       (tsig),
        .d          (d),
        .i_bit      (i_bit),
        .r          (r),
        .s          (s),
        .ien        (ien),
        .phase      (phase),
        .instr_done (instr_done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One clock: SC follows the controls seen just before the edge.
    task automatic tick();
        logic ci, cc;
        #1;
        ci = sc_inc;
        cc = sc_clr;
        @(posedge clk);
        #1;
        if (cc)      t = '0;
        else if (ci) t = t + 1'b1;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; t = '0; ir = '0; fgi = 1'b0; fgo = 1'b0;
        #2;
        chk("rst_clr", sc_clr, 1);
        chk("rst_inc", sc_inc, 0);
        chk("rst_ph", phase, 0);
        ticks(2);
        rst = 1'b0;
        #1;
        chk("idle_s", s, 0);
        chk("idle_d", d, 0);
        chk("idle_err", err, 0);
        chk("idle_ien", ien, 0);
        chk("idle_clr", sc_clr, 0);
        chk("idle_tsig", tsig, 16'h0001);

        // LDA direct
        ir = 16'h2123; start = 1'b1;
        tick();
        start = 1'b0;
        chk("lda_s", s, 1);
        chk("lda_ph0", phase, 1);
        chk("lda_inc0", sc_inc, 1);
        tick();
        chk("lda_ph1", phase, 1);
        tick();
        chk("lda_ph2", phase, 2);
        chk("lda_tsig2", tsig, 16'h0004);
        tick();
        chk("lda_t3", t, 3);
        chk("lda_d", d, 8'b0000_0100);
        chk("lda_i", i_bit, 0);
        chk("lda_ph3", phase, 4);
        chk("lda_clr3", sc_clr, 0);
        tick();
        chk("lda_ph4", phase, 4);
        chk("lda_done4", instr_done, 0);
        tick();
        chk("lda_t5", t, 5);
        chk("lda_clr5", sc_clr, 1);
        chk("lda_done5", instr_done, 1);
        chk("lda_ph5", phase, 4);
        tick();
        chk("lda_wrap", t, 0);

        // ISZ indirect
        ir = 16'hE010;
        ticks(3);
        chk("isz_ph3", phase, 3);
        chk("isz_d", d, 8'b0100_0000);
        chk("isz_i", i_bit, 1);
        tick();
        chk("isz_done4", instr_done, 0);
        tick();
        chk("isz_done5", instr_done, 0);
        chk("isz_clr5", sc_clr, 0);
        tick();
        chk("isz_t6", t, 6);
        chk("isz_clr6", sc_clr, 1);
        chk("isz_done6", instr_done, 1);
        tick();

        // ION, then interrupt entry during a register-reference
        ir = 16'hF080;
        ticks(3);
        chk("ion_clr", sc_clr, 1);
        chk("ion_done", instr_done, 1);
        tick();
        chk("ion_ien", ien, 1);
        ir = 16'h7800;
        ticks(3);
        fgi = 1'b1;
        chk("ent_clr", sc_clr, 1);
        tick();
        fgi = 1'b0;
        chk("ent_r", r, 1);
        chk("ent_t", t, 0);
        chk("rt0_ph", phase, 5);
        chk("rt0_inc", sc_inc, 1);
        tick();
        chk("rt1_ph", phase, 5);
        tick();
        chk("rt2_ph", phase, 5);
        chk("rt2_clr", sc_clr, 1);
        chk("rt2_done", instr_done, 0);
        tick();
        chk("rtx_r", r, 0);
        chk("rtx_ien", ien, 0);
        chk("rtx_ph", phase, 1);

        // HLT
        ir = 16'h7001;
        ticks(4);
        chk("hlt_s", s, 0);
        chk("hlt_t", t, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("hlt_inc", sc_inc, 0);
            chk("hlt_ph", phase, 0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_s", s, 1);
        chk("rs_t", t, 0);
        chk("rs_ph", phase, 1);

        // ION then reset in the middle of an ADD
        ir = 16'hF080;
        ticks(4);
        chk("ion2_ien", ien, 1);
        ir = 16'h1000;
        ticks(4);
        chk("add_t4", t, 4);
        chk("add_d", d, 8'b0000_0010);
        rst = 1'b1;
        #1;
        chk("mrst_clr", sc_clr, 1);
        chk("mrst_inc", sc_inc, 0);
        chk("mrst_done", instr_done, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_s", s, 0);
        chk("mrst_r", r, 0);
        chk("mrst_ien", ien, 0);
        chk("mrst_d", d, 0);
        chk("mrst_ph", phase, 0);
        chk("mrst_t", t, 0);

        // Illegal count
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 4'd9;
        #1;
        chk("ill_clr", sc_clr, 1);
        chk("ill_inc", sc_inc, 0);
        chk("ill_err0", err, 0);
        chk("ill_tsig", tsig, 16'h0200);
        tick();
        chk("ill_err1", err, 1);
        chk("ill_t", t, 0);
        chk("ill_ph", phase, 1);

        // IOF with interrupt entry on the same edge
        ir = 16'hF080;
        ticks(4);
        chk("ion3_ien", ien, 1);
        ir = 16'hF040;
        ticks(3);
        fgo = 1'b1;
        tick();
        fgo = 1'b0;
        chk("iof_r", r, 1);
        chk("iof_ien", ien, 0);
        chk("iof_err", err, 1);
        ticks(3);
        chk("iof_rx", r, 0);
        chk("err_sticky", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("err_rst", err, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
